// File: rtl/draw_engine.sv
// Pixel compositor for the Brick-Breaker display: object hit tests, a brick hit-flash
// timer, and a priority colour select. The output follows the scan position by 2 cycles.
module draw_engine #(
    parameter int NUM_BRICKS   = 6,
    parameter int COORD_W      = 9,
    parameter int PIX_W        = 10,
    parameter int BALL_SIZE    = 20,
    parameter int PADDLE_W     = 74,
    parameter int PADDLE_Y0    = 458,
    parameter int PADDLE_Y1    = 477,
    parameter int BRICK_W      = 57,
    parameter int BRICK_H      = 19,
    parameter int WALL_L0      = 127,
    parameter int WALL_L1      = 134,
    parameter int WALL_R0      = 505,
    parameter int WALL_R1      = 511,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [1:0]                      mode,
    input  logic                            frame_start,
    input  logic [PIX_W-1:0]                pixel_x,
    input  logic [PIX_W-1:0]                pixel_y,
    input  logic [COORD_W-1:0]              paddle_x,
    input  logic [COORD_W-1:0]              ball_x,
    input  logic [COORD_W-1:0]              ball_y,
    input  logic [NUM_BRICKS*COORD_W-1:0]   brick_x,
    input  logic [NUM_BRICKS*COORD_W-1:0]   brick_y,
    input  logic [NUM_BRICKS-1:0]           bricks_exist,
    output logic [7:0]                      color_out,
    output logic [NUM_BRICKS-1:0]           flashing
);

    // One spare bit so that coordinate + object size can never wrap.
    localparam int EW = PIX_W + 1;
    typedef logic [EW-1:0] ext_t;

    localparam ext_t BALL_LEN   = ext_t'(BALL_SIZE);
    localparam ext_t PADDLE_LEN = ext_t'(PADDLE_W);
    localparam ext_t PADDLE_TOP = ext_t'(PADDLE_Y0);
    localparam ext_t PADDLE_BOT = ext_t'(PADDLE_Y1);
    localparam ext_t BRICK_LEN  = ext_t'(BRICK_W);
    localparam ext_t BRICK_HGT  = ext_t'(BRICK_H);
    localparam ext_t WL0        = ext_t'(WALL_L0);
    localparam ext_t WL1        = ext_t'(WALL_L1);
    localparam ext_t WR0        = ext_t'(WALL_R0);
    localparam ext_t WR1        = ext_t'(WALL_R1);

    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);
    localparam logic [7:0] C_BLACK    = 8'h00;
    localparam logic [7:0] C_RED      = 8'hE0;
    localparam logic [7:0] C_WHITE    = 8'hFF;

    typedef enum logic [1:0] {
        MODE_PLAY = 2'd0,
        MODE_LOSE = 2'd1,
        MODE_WIN  = 2'd2,
        MODE_ALT  = 2'd3
    } mode_e;

    typedef struct packed {
        logic                  en;
        mode_e                 mode;
        logic                  ball;
        logic                  paddle;
        logic [NUM_BRICKS-1:0] brick_white;
        logic [NUM_BRICKS-1:0] brick_red;
        logic                  wall;
        logic                  play;
    } s1_t;

    function automatic logic in_span(input ext_t p, input ext_t lo, input ext_t len);
        return (p >= lo) && (p < ext_t'(lo + len));
    endfunction

    ext_t px;
    ext_t py;
    s1_t  s1_d;
    s1_t  s1_q;

    assign px = ext_t'(pixel_x);
    assign py = ext_t'(pixel_y);

    logic [NUM_BRICKS-1:0] brick_white_c;
    logic [NUM_BRICKS-1:0] brick_red_c;

    for (genvar i = 0; i < NUM_BRICKS; i++) begin : g_brick
        logic hit;
        assign hit = in_span(px, ext_t'(brick_x[i*COORD_W +: COORD_W]), BRICK_LEN) &&
                     in_span(py, ext_t'(brick_y[i*COORD_W +: COORD_W]), BRICK_HGT);
        assign brick_white_c[i] = hit &  bricks_exist[i];
        assign brick_red_c[i]   = hit & ~bricks_exist[i] & flashing[i];
    end

    // ---------------- Stage 1: hit tests ----------------
    always_comb begin
        s1_d             = '0;
        s1_d.en          = start;
        s1_d.mode        = mode_e'(mode);
        s1_d.ball        = in_span(px, ext_t'(ball_x), BALL_LEN) &&
                           in_span(py, ext_t'(ball_y), BALL_LEN);
        s1_d.paddle      = in_span(px, ext_t'(paddle_x), PADDLE_LEN) &&
                           (py >= PADDLE_TOP) && (py <= PADDLE_BOT);
        s1_d.brick_white = brick_white_c;
        s1_d.brick_red   = brick_red_c;
        s1_d.wall        = ((px >= WL0) && (px < WL1)) || ((px >= WR0) && (px < WR1));
        s1_d.play        = (px >= WL1) && (px < WR0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s1_q <= '0;
        else      s1_q <= s1_d;
    end

    // ---------------- Flash counters ----------------
    logic [7:0]            flash_cnt [NUM_BRICKS];
    logic [7:0]            cnt_d     [NUM_BRICKS];
    logic [NUM_BRICKS-1:0] hist;

    always_comb begin
        for (int i = 0; i < NUM_BRICKS; i++) begin
            cnt_d[i] = flash_cnt[i];
            if (!start)
                cnt_d[i] = 8'd0;
            else if (hist[i] && !bricks_exist[i])
                cnt_d[i] = FLASH_LOAD;           // load beats a coincident frame_start
            else if (!hist[i] && bricks_exist[i])
                cnt_d[i] = 8'd0;
            else if (frame_start && (flash_cnt[i] != 8'd0))
                cnt_d[i] = flash_cnt[i] - 8'd1;
        end
    end

    // NOTE: the counter array gets an explicit async reset like every other register;
    // it is control state, not a storage memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist     <= '0;
            flashing <= '0;
            for (int i = 0; i < NUM_BRICKS; i++) flash_cnt[i] <= 8'd0;
        end else begin
            hist <= bricks_exist;
            for (int i = 0; i < NUM_BRICKS; i++) begin
                flash_cnt[i] <= cnt_d[i];
                flashing[i]  <= (cnt_d[i] != 8'd0);
            end
        end
    end

    // ---------------- Stage 2: priority select ----------------
    logic [7:0] color_d;
    logic [7:0] brick_color;
    logic       brick_any;

    // NOTE: every combinational output is defaulted before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        color_d     = C_BLACK;
        brick_color = C_BLACK;
        brick_any   = 1'b0;
        // Scan downwards so the lowest drawn index is the one left standing.
        for (int i = NUM_BRICKS - 1; i >= 0; i--) begin
            if (s1_q.brick_white[i] || s1_q.brick_red[i]) begin
                brick_any   = 1'b1;
                brick_color = s1_q.brick_white[i] ? C_WHITE : C_RED;
            end
        end

        if (!s1_q.en)
            color_d = C_BLACK;
        else if (s1_q.ball)
            color_d = (s1_q.mode == MODE_LOSE) ? C_WHITE : C_RED;
        else if (s1_q.paddle)
            color_d = C_WHITE;
        else if (brick_any)
            color_d = brick_color;
        else if (s1_q.wall)
            color_d = C_WHITE;
        else if (s1_q.play) begin
            case (s1_q.mode)
                MODE_LOSE: color_d = C_RED;
                MODE_WIN:  color_d = C_WHITE;
                default:   color_d = C_BLACK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) color_out <= C_BLACK;
        else      color_out <= color_d;
    end

endmodule
